// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
//   Round-robin burst read controller for one synchronous-read ROM shared by two
//   requesters. A granted burst streams len+1 consecutive (wrapping) addresses to
//   the ROM and returns each word to its owner as a one-cycle response pulse,
//   with the final beat flagged.
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   reqN_valid/addr/len       burst request from requester N (len = beats - 1)
//   reqN_ready                request accepted on valid & ready at a rising edge
//   rspN_valid/data/last      response stream to requester N
//   rom_addr                  registered ROM address
//   rom_dout                  ROM read data (one-cycle registered latency)
//   busy                      controller is not idle
module rom_burst_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [LEN_WIDTH-1:0]  req0_len,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp0_last,

    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [LEN_WIDTH-1:0]  req1_len,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  rsp1_last,

    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic                   last_grant;
    // Stage 1 describes the address currently on rom_addr; stage 2 describes the
    // word currently on rom_dout.
    logic                   s1_valid;
    logic                   s1_owner;
    logic                   s2_valid;
    logic                   s2_last;
    logic                   s2_owner;

    logic                   idle;
    logic                   accept;
    logic                   sel;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;

    assign idle = (state == IDLE);
    assign busy = ~idle;

    // On a tie the port that was not granted last wins. Ready is held low while
    // reset is asserted so nothing can be handshaken during reset.
    assign req0_ready = idle & ~rst & req0_valid & (~req1_valid | last_grant);
    assign req1_ready = idle & ~rst & req1_valid & (~req0_valid | ~last_grant);

    assign accept   = req0_ready | req1_ready;
    assign sel      = req1_ready;
    assign sel_addr = sel ? req1_addr : req0_addr;
    assign sel_len  = sel ? req1_len  : req0_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            last_grant <= 1'b1;
            rom_addr   <= '0;
            s1_valid   <= 1'b0;
            s1_owner   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_owner   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_last  <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_last  <= 1'b0;
        end else begin
            // Return pipeline: route the word on rom_dout to the stage-2 owner.
            rsp0_valid <= s2_valid & ~s2_owner;
            rsp0_last  <= s2_valid & s2_last & ~s2_owner;
            rsp1_valid <= s2_valid & s2_owner;
            rsp1_last  <= s2_valid & s2_last & s2_owner;
            if (s2_valid && !s2_owner) rsp0_data <= rom_dout;
            if (s2_valid &&  s2_owner) rsp1_data <= rom_dout;

            // The address on rom_addr is the last one when no beats remain.
            s2_valid <= s1_valid;
            s2_last  <= s1_valid & (remaining == '0);
            s2_owner <= s1_owner;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rom_addr   <= sel_addr;
                        remaining  <= sel_len;
                        s1_valid   <= 1'b1;
                        s1_owner   <= sel;
                        last_grant <= sel;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (remaining == '0) begin
                        s1_valid <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        rom_addr  <= rom_addr + 1'b1;  // wraps naturally
                        remaining <= remaining - 1'b1;
                    end
                end
                DRAIN: begin
                    // Leave at the edge that registers the owner's last response.
                    if (s2_valid && s2_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
module tb_rom_burst_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int LW = 4;
    localparam int N  = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          rv [2];
    logic [AW-1:0] ra [2];
    logic [LW-1:0] rl [2];
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp0_last, rsp1_valid, rsp1_last;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic          busy;

    always #5 clk = ~clk;

    rom_burst_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (rv[0]),
        .req0_addr  (ra[0]),
        .req0_len   (rl[0]),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_last  (rsp0_last),
        .req1_valid (rv[1]),
        .req1_addr  (ra[1]),
        .req1_len   (rl[1]),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_last  (rsp1_last),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .busy       (busy)
    );

    // ROM: 0x00..0x77 at 0..7, 0xFF at 8..15, one-cycle registered read.
    logic [DW-1:0] rom [16];
    always @(posedge clk) rom_dout <= rom[rom_addr];

    // Reference model: expected outputs indexed by edge number.
    int            cyc, free_at, nacc, nvec, nmis;
    bit            lg, hold;
    bit            acc_now [2];
    bit            ev [2][N];
    bit            el [2][N];
    logic [DW-1:0] ed [2][N];
    bit            eb [N];
    logic [AW-1:0] ea [N];
    logic [DW-1:0] cur_d [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s edge=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_from(input int m);
        for (int i = m; i < N; i++) begin
            ev[0][i] = 0; ev[1][i] = 0; el[0][i] = 0; el[1][i] = 0;
            ed[0][i] = '0; ed[1][i] = '0; eb[i] = 0; ea[i] = '0;
        end
    endtask

    // Burst accepted at edge cyc: beat k returned at edge cyc+2+k.
    task automatic schedule(input int g, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int len;
        len     = int'(l);
        lg      = (g == 1);
        free_at = cyc + 3 + len;
        for (int k = 0; k <= len; k++) begin
            ev[g][cyc+2+k] = 1;
            ed[g][cyc+2+k] = rom[AW'(int'(a) + k)];
            el[g][cyc+2+k] = (k == len);
        end
        for (int m = cyc; m <= cyc + 1 + len; m++) eb[m] = 1;
        for (int m = cyc; m < N; m++)
            ea[m] = AW'(int'(a) + ((m - cyc) <= len ? (m - cyc) : len));
    endtask

    task automatic step();
        bit e0, e1;
        int g;
        @(negedge clk);
        e0 = (cyc >= free_at) && rv[0] && (!rv[1] || lg);
        e1 = (cyc >= free_at) && rv[1] && (!rv[0] || !lg);
        chk("ready0", 32'(req0_ready), 32'(e0));
        chk("ready1", 32'(req1_ready), 32'(e1));
        acc_now[0] = 0;
        acc_now[1] = 0;
        if (e0 || e1) begin
            g = e1 ? 1 : 0;
            schedule(g, ra[g], rl[g]);
            acc_now[g] = 1;
            nacc++;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) if (ev[p][cyc]) cur_d[p] = ed[p][cyc];
        chk("rsp0_valid", 32'(rsp0_valid), 32'(ev[0][cyc]));
        chk("rsp0_last",  32'(rsp0_last),  32'(el[0][cyc]));
        chk("rsp0_data",  32'(rsp0_data),  32'(cur_d[0]));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(ev[1][cyc]));
        chk("rsp1_last",  32'(rsp1_last),  32'(el[1][cyc]));
        chk("rsp1_data",  32'(rsp1_data),  32'(cur_d[1]));
        chk("busy",       32'(busy),       32'(eb[cyc]));
        chk("rom_addr",   32'(rom_addr),   32'(ea[cyc]));
        cyc++;
        for (int p = 0; p < 2; p++) if (acc_now[p] && !hold) rv[p] = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready0"}, 32'(req0_ready), 0);
        chk({tag, "_ready1"}, 32'(req1_ready), 0);
        chk({tag, "_rsp0_valid"}, 32'(rsp0_valid), 0);
        chk({tag, "_rsp0_last"},  32'(rsp0_last), 0);
        chk({tag, "_rsp0_data"},  32'(rsp0_data), 0);
        chk({tag, "_rsp1_valid"}, 32'(rsp1_valid), 0);
        chk({tag, "_rsp1_last"},  32'(rsp1_last), 0);
        chk({tag, "_rsp1_data"},  32'(rsp1_data), 0);
        chk({tag, "_busy"},       32'(busy), 0);
        chk({tag, "_rom_addr"},   32'(rom_addr), 0);
    endtask

    // Called just after an edge; reset spans the following edge.
    task automatic do_reset();
        rst   = 1'b1;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        #1;
        chk_zero("rst_async");
        clear_from(cyc);
        free_at  = 0;
        lg       = 1;
        cur_d[0] = '0;
        cur_d[1] = '0;
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        cyc++;
        rst = 1'b0;
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        while ((cyc < free_at || rv[0] || rv[1]) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            nvec++;
            nmis++;
            $error("FAIL run_idle_timeout edge=%0d got=busy want=idle", cyc);
        end
    endtask

    task automatic req(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l);
        rv[p] = 1'b1;
        ra[p] = a;
        rl[p] = l;
    endtask

    initial begin
        int e, target;
        for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? DW'(i * 8'h11) : 8'hFF;
        nvec = 0; nmis = 0; nacc = 0; cyc = 0; free_at = 0; lg = 1; hold = 0;
        cur_d[0] = '0; cur_d[1] = '0;
        clear_from(0);
        rst = 1'b1;

        // Tie from reset: req0 wins first, req1 follows at E+3.
        req(0, 4'd0, 4'd0);
        req(1, 4'd7, 4'd1);
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_idle();

        // Single burst and wrap-around.
        req(0, 4'd3, 4'd2);
        run_idle();
        req(1, 4'd14, 4'd3);
        run_idle();

        // Fairness: both held valid for four bursts.
        req(0, 4'd5, 4'd1);
        req(1, 4'd9, 4'd1);
        hold   = 1;
        target = nacc + 4;
        for (int n = 0; n < 200 && nacc < target; n++) step();
        hold  = 0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        run_idle();

        // Maximum length.
        req(0, 4'd0, 4'd15);
        run_idle();

        // Reset after beat 1 of a six-beat burst, then a lone single-beat req1.
        req(0, 4'd4, 4'd5);
        target = nacc + 1;
        for (int n = 0; n < 20 && nacc < target; n++) step();
        e = cyc - 1;
        while (cyc < e + 4) step();
        do_reset();
        for (int n = 0; n < 4; n++) step();
        req(1, 4'd2, 4'd0);
        run_idle();

        // Random traffic with occasional resets.
        for (int n = 0; n < 500 && cyc < N - 40; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rv[p] && $urandom_range(0, 2) == 0) begin
                    req(p, AW'($urandom), ($urandom_range(0, 3) == 0) ?
                        LW'($urandom) : LW'($urandom_range(0, 2)));
                end
            end
            if ($urandom_range(0, 149) == 0) do_reset();
            else step();
        end
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        run_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
